// File: rtl/bobing_pkg.sv
// Shared types and constants for the BoBing dice roller.
package bobing_pkg;

   typedef logic [2:0] die_t;

   localparam die_t FACE_MIN = 3'd1;
   localparam die_t FACE_MAX = 3'd6;
   localparam int   NUM_DICE = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROLL = 2'd1,
      DONE = 2'd2
   } state_t;

   // A three-bit LFSR sample is a legal face only inside 1..6; 0 and 7 are discarded.
   function automatic logic is_face(die_t c);
      return (c >= FACE_MIN) && (c <= FACE_MAX);
   endfunction

endpackage

// File: rtl/bobing_dice_roller_if.sv
// Request/result bundle between the dice roller and its consumer (scorer side).
interface bobing_dice_roller_if #(
   parameter int LFSR_W = 16
);
   import bobing_pkg::*;

   logic              seed_load;
   logic [LFSR_W-1:0] seed;
   logic              roll_req;
   logic              roll_ack;
   die_t              D1;
   die_t              D2;
   die_t              D3;
   die_t              D4;
   die_t              D5;
   die_t              D6;
   logic              roll_busy;
   logic              roll_valid;
   logic [7:0]        reject_cnt;

   // Consumer side: issues requests and seeds, reads the dice.
   modport master (
      output seed_load, seed, roll_req, roll_ack,
      input  D1, D2, D3, D4, D5, D6, roll_busy, roll_valid, reject_cnt
   );

   // Roller side: accepts requests and seeds, produces the dice.
   modport slave (
      input  seed_load, seed, roll_req, roll_ack,
      output D1, D2, D3, D4, D5, D6, roll_busy, roll_valid, reject_cnt
   );

endinterface

// File: rtl/bobing_lfsr.sv
// Right-shift Galois LFSR with seed load; a zero seed is replaced by the default
// so the register can never lock up in the all-zero state.
module bobing_lfsr #(
   parameter int          W       = 16,
   parameter logic [W-1:0] TAPS    = 16'hB400,
   parameter logic [W-1:0] DEFAULT = 16'hACE1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic [W-1:0] seed,
   output logic [W-1:0] state
);

   logic [W-1:0] lfsr_q;
   logic [W-1:0] lfsr_d;

   // Next value: load wins over step; otherwise hold.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = (seed == '0) ? DEFAULT : seed;
      end else if (step) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
      end
   end

   // State register, synchronous reset back to the default seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= DEFAULT;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state = lfsr_q;

endmodule

// File: rtl/bobing_dice_roller.sv
// BoBing dice source: draws six legal faces from an LFSR by rejection sampling and
// holds them with roll_valid until the consumer acknowledges or asks for another roll.
module bobing_dice_roller
   import bobing_pkg::*;
#(
   parameter int               LFSR_W       = 16,
   parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
   parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   bobing_dice_roller_if.slave  bus
);

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  reject_cnt_q, reject_cnt_d;
   logic        busy_q, busy_d;
   logic        valid_q, valid_d;
   die_t        dice_q [NUM_DICE];
   die_t        dice_d [NUM_DICE];

   logic [LFSR_W-1:0] lfsr_state;
   logic              lfsr_load;
   logic              lfsr_step;
   die_t              sample;
   logic              start_roll;
   logic              lfsr_unused;

   // Seeds are only accepted while no roll is in flight; the LFSR advances once per ROLL cycle.
   assign lfsr_load   = bus.seed_load && (state_q != ROLL);
   assign lfsr_step   = (state_q == ROLL);
   assign sample      = lfsr_state[2:0];
   assign lfsr_unused = ^lfsr_state[LFSR_W-1:3];

   bobing_lfsr #(
      .W       (LFSR_W),
      .TAPS    (TAPS),
      .DEFAULT (SEED_DEFAULT)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .seed  (bus.seed),
      .state (lfsr_state)
   );

   // Control FSM: start/accept/reject/complete decisions and the next value of every register.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      reject_cnt_d = reject_cnt_q;
      busy_d       = busy_q;
      valid_d      = valid_q;
      dice_d       = dice_q;
      start_roll   = 1'b0;

      case (state_q)
         IDLE: begin
            start_roll = bus.roll_req;
         end
         ROLL: begin
            if (is_face(sample)) begin
               dice_d[idx_q] = sample;
               if (idx_q == 3'(NUM_DICE - 1)) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  valid_d = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else if (reject_cnt_q != 8'hFF) begin
               reject_cnt_d = reject_cnt_q + 8'd1;
            end
         end
         DONE: begin
            if (bus.roll_req) begin
               start_roll = 1'b1;
            end else if (bus.roll_ack) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (start_roll) begin
         state_d      = ROLL;
         idx_d        = 3'd0;
         reject_cnt_d = 8'd0;
         busy_d       = 1'b1;
         valid_d      = 1'b0;
         for (int i = 0; i < NUM_DICE; i++) begin
            dice_d[i] = 3'd0;
         end
      end
   end

   // Registers for state, counters, flags and dice; reset aborts any roll in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= 3'd0;
         reject_cnt_q <= 8'd0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         for (int i = 0; i < NUM_DICE; i++) begin
            dice_q[i] <= 3'd0;
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         reject_cnt_q <= reject_cnt_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         for (int i = 0; i < NUM_DICE; i++) begin
            dice_q[i] <= dice_d[i];
         end
      end
   end

   assign bus.D1         = dice_q[0];
   assign bus.D2         = dice_q[1];
   assign bus.D3         = dice_q[2];
   assign bus.D4         = dice_q[3];
   assign bus.D5         = dice_q[4];
   assign bus.D6         = dice_q[5];
   assign bus.roll_busy  = busy_q;
   assign bus.roll_valid = valid_q;
   assign bus.reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_bobing_dice_roller.sv
// Bench for the BoBing dice roller: directed scenarios followed by randomized rolls,
// each compared against a high-level model of the LFSR draw and rejection rules.
module tb_bobing_dice_roller;

   localparam int unsigned TAPS_M    = 32'h0000B400;
   localparam int unsigned DEFAULT_M = 32'h0000ACE1;
   localparam int          BOUND     = 3000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int testCount = 0;
   int failCount = 0;

   // Model state: LFSR value, last drawn faces, reject count and cycles spent rolling.
   int unsigned mLfsr = DEFAULT_M;
   int          mDice [6];
   int          mRej;
   int          mCycles;

   bobing_dice_roller_if #(.LFSR_W(16)) bus ();

   bobing_dice_roller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Advance one clock edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs, then return them to idle.
   task automatic applyStimulus(input logic r, input logic sl, input logic [15:0] sd,
                                input logic rq, input logic ak);
      rst           = r;
      bus.seed_load = sl;
      bus.seed      = sd;
      bus.roll_req  = rq;
      bus.roll_ack  = ak;
      tick();
      rst           = 1'b0;
      bus.seed_load = 1'b0;
      bus.roll_req  = 1'b0;
      bus.roll_ack  = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [17:0] dutDice();
      return {bus.D1, bus.D2, bus.D3, bus.D4, bus.D5, bus.D6};
   endfunction

   function automatic logic [17:0] modelDice();
      logic [17:0] p;
      p = '0;
      for (int i = 0; i < 6; i++) begin
         p = {p[14:0], 3'(mDice[i])};
      end
      return p;
   endfunction

   function automatic void modelLoad(input int unsigned s);
      mLfsr = (s == 0) ? DEFAULT_M : s;
   endfunction

   // Draw six faces: each cycle takes the low three bits, keeps 1..6, then advances the LFSR.
   function automatic void modelRoll();
      int got;
      int c;
      got     = 0;
      mRej    = 0;
      mCycles = 0;
      while (got < 6) begin
         c = int'(mLfsr % 8);
         if (c >= 1 && c <= 6) begin
            mDice[got] = c;
            got++;
         end else if (mRej < 255) begin
            mRej++;
         end
         mCycles++;
         mLfsr = (mLfsr / 2) ^ (((mLfsr % 2) == 1) ? TAPS_M : 32'd0);
      end
   endfunction

   // Called just after the roll-start edge: checks the cleared outputs, waits for completion, checks the result.
   task automatic waitAndCheck(input string tag, input logic noise);
      int n;
      logic [17:0] d;
      checkOutput({tag, "_start_busy"}, 32'(bus.roll_busy), 32'd1);
      checkOutput({tag, "_start_valid"}, 32'(bus.roll_valid), 32'd0);
      checkOutput({tag, "_start_dice"}, 32'(dutDice()), 32'd0);
      n = 0;
      while (!bus.roll_valid && n < BOUND) begin
         if (noise) begin
            bus.seed_load = 1'($urandom_range(0, 1));
            bus.seed      = 16'($urandom);
            bus.roll_req  = 1'($urandom_range(0, 1));
            bus.roll_ack  = 1'($urandom_range(0, 1));
         end
         tick();
         n++;
         bus.seed_load = 1'b0;
         bus.roll_req  = 1'b0;
         bus.roll_ack  = 1'b0;
         if (bus.roll_valid && bus.roll_busy) begin
            checkOutput({tag, "_valid_busy_excl"}, 32'd1, 32'd0);
         end
      end
      checkOutput({tag, "_latency"}, 32'(n), 32'(mCycles));
      checkOutput({tag, "_dice"}, 32'(dutDice()), 32'(modelDice()));
      checkOutput({tag, "_reject_cnt"}, 32'(bus.reject_cnt), 32'(mRej));
      checkOutput({tag, "_busy_done"}, 32'(bus.roll_busy), 32'd0);
      d = dutDice();
      for (int i = 0; i < 6; i++) begin
         if (d[3*i +: 3] < 3'd1 || d[3*i +: 3] > 3'd6) begin
            checkOutput({tag, "_face_range"}, 32'(d[3*i +: 3]), 32'd1);
         end
      end
   endtask

   logic [17:0] scen2Dice;
   logic [17:0] held;
   int          mode;
   logic [15:0] rs;

   initial begin
      scen2Dice     = {3'd1, 3'd4, 3'd6, 3'd3, 3'd1, 3'd4};
      bus.seed_load = 1'b0;
      bus.seed      = 16'h0000;
      bus.roll_req  = 1'b0;
      bus.roll_ack  = 1'b0;

      // Reset, then idle.
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("reset_dice", 32'(dutDice()), 32'd0);
      checkOutput("reset_valid", 32'(bus.roll_valid), 32'd0);
      checkOutput("reset_busy", 32'(bus.roll_busy), 32'd0);
      checkOutput("reset_reject_cnt", 32'(bus.reject_cnt), 32'd0);

      // First roll from the default seed after idling (LFSR must have stayed frozen).
      mLfsr = DEFAULT_M;
      modelRoll();
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      waitAndCheck("scen2", 1'b0);
      checkOutput("scen2_known_dice", 32'(dutDice()), 32'(scen2Dice));
      checkOutput("scen2_known_rej", 32'(bus.reject_cnt), 32'd3);

      // Zero seed substitutes the default seed.
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
      checkOutput("scen3_valid_kept", 32'(bus.roll_valid), 32'd1);
      modelLoad(0);
      modelRoll();
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      waitAndCheck("scen3", 1'b0);
      checkOutput("scen3_known_dice", 32'(dutDice()), 32'(scen2Dice));

      // Acknowledge clears valid but keeps the dice.
      held = dutDice();
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      checkOutput("scen4_ack_valid", 32'(bus.roll_valid), 32'd0);
      checkOutput("scen4_ack_dice", 32'(dutDice()), 32'(held));
      checkOutput("scen4_ack_busy", 32'(bus.roll_busy), 32'd0);

      // Roll from IDLE with inputs toggling during ROLL (all must be ignored).
      modelRoll();
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      waitAndCheck("scen4_noise", 1'b1);

      // Request and acknowledge together in DONE: the new roll wins.
      modelRoll();
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      waitAndCheck("scen4_req_ack", 1'b0);

      // Reset three cycles into a roll aborts it.
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("scen5_dice", 32'(dutDice()), 32'd0);
      checkOutput("scen5_valid", 32'(bus.roll_valid), 32'd0);
      checkOutput("scen5_busy", 32'(bus.roll_busy), 32'd0);
      checkOutput("scen5_reject_cnt", 32'(bus.reject_cnt), 32'd0);
      mLfsr = DEFAULT_M;
      modelRoll();
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      waitAndCheck("scen5_reroll", 1'b0);
      checkOutput("scen5_known_dice", 32'(dutDice()), 32'(scen2Dice));

      // Randomized seeds and request patterns.
      for (int r = 0; r < 150; r++) begin
         mode = int'($urandom_range(0, 3));
         rs   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         case (mode)
            1: begin
               applyStimulus(1'b0, 1'b1, rs, 1'b0, 1'b0);
               modelLoad(32'(rs));
               modelRoll();
               applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
            end
            2: begin
               modelLoad(32'(rs));
               modelRoll();
               applyStimulus(1'b0, 1'b1, rs, 1'b1, 1'b0);
            end
            3: begin
               held = dutDice();
               applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
               checkOutput("rand_ack_valid", 32'(bus.roll_valid), 32'd0);
               checkOutput("rand_ack_dice", 32'(dutDice()), 32'(held));
               modelRoll();
               applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
            end
            default: begin
               modelRoll();
               applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
            end
         endcase
         waitAndCheck("rand", 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
